tile_rom_arbiter: RTL and testbench

- Parametrised tile-ROM fetch arbiter for tilemap generators.
- Replaces the per-chip hard-wired two-layer request/ack toggle logic with an N-channel arbiter.
- Each layer fetcher posts one pending ROM read (address plus tag). The arbiter serialises the reads onto the single toggle-handshake ROM port and returns the data with a per-channel load strobe and the original tag, so that channel's shifter can load it.

---
 rtl/tile_rom_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_tile_rom_arbiter.sv | 419 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tile_rom_arbiter.sv
// N-channel tile-ROM fetch arbiter: one pending read slot per layer fetcher, serialised
// onto a single toggle-handshake ROM port, data returned with a per-channel load strobe.
module tile_rom_arbiter #(
    parameter int unsigned NUM_CH    = 2,
    parameter int unsigned ADDR_W    = 21,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned TAG_W     = 2,
    parameter int unsigned PRIO_MODE = 0
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic [NUM_CH-1:0]        ch_req,
    input  logic [NUM_CH*ADDR_W-1:0] ch_addr,
    input  logic [NUM_CH*TAG_W-1:0]  ch_tag,
    output logic [NUM_CH-1:0]        ch_busy,
    output logic [NUM_CH-1:0]        load,
    output logic [DATA_W-1:0]        load_data,
    output logic [TAG_W-1:0]         load_tag,
    output logic [NUM_CH-1:0]        overrun,
    input  logic                     overrun_clr,
    output logic [ADDR_W-1:0]        rom_address,
    output logic                     rom_req,
    input  logic                     rom_ack,
    input  logic [DATA_W-1:0]        rom_data
);

    localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic {
        ST_IDLE,
        ST_WAIT
    } state_t;

    state_t              state_q, state_d;
    logic [NUM_CH-1:0]   pend_q, pend_d;
    logic [ADDR_W-1:0]   addr_q [NUM_CH];
    logic [ADDR_W-1:0]   addr_d [NUM_CH];
    logic [TAG_W-1:0]    tag_q  [NUM_CH];
    logic [TAG_W-1:0]    tag_d  [NUM_CH];
    logic [NUM_CH-1:0]   overrun_q, overrun_d;
    logic [NUM_CH-1:0]   load_q, load_d;
    logic [DATA_W-1:0]   load_data_q, load_data_d;
    logic [TAG_W-1:0]    load_tag_q, load_tag_d;
    logic [CH_W-1:0]     flight_q, flight_d;
    logic [TAG_W-1:0]    flight_tag_q, flight_tag_d;
    logic [CH_W-1:0]     last_q, last_d;
    logic [ADDR_W-1:0]   rom_addr_q, rom_addr_d;
    logic                rom_req_q, rom_req_d;

    logic [CH_W-1:0]     win;
    logic                win_vld;
    logic                issue;

    // Scan from the farthest candidate to the nearest so the last hit is the winner.
    always_comb begin
        win     = '0;
        win_vld = 1'b0;
        if (PRIO_MODE == 1 || NUM_CH == 1) begin
            for (int unsigned i = NUM_CH; i > 0; i--) begin
                if (pend_q[i-1]) begin
                    win     = CH_W'(i - 1);
                    win_vld = 1'b1;
                end
            end
        end else begin
            for (int unsigned d = NUM_CH; d > 0; d--) begin
                int unsigned idx;
                idx = (32'(last_q) + d) % NUM_CH;
                if (pend_q[idx]) begin
                    win     = CH_W'(idx);
                    win_vld = 1'b1;
                end
            end
        end
    end

    // A stale ack left over from before reset keeps rom_ack != rom_req and blocks issue.
    assign issue = (state_q == ST_IDLE) && (rom_req_q == rom_ack) && win_vld;

    always_comb begin
        state_d      = state_q;
        pend_d       = pend_q;
        addr_d       = addr_q;
        tag_d        = tag_q;
        overrun_d    = overrun_q;
        load_d       = '0;
        load_data_d  = load_data_q;
        load_tag_d   = load_tag_q;
        flight_d     = flight_q;
        flight_tag_d = flight_tag_q;
        last_d       = last_q;
        rom_addr_d   = rom_addr_q;
        rom_req_d    = rom_req_q;

        case (state_q)
            ST_IDLE: begin
                if (issue) begin
                    rom_addr_d   = addr_q[win];
                    rom_req_d    = ~rom_req_q;
                    pend_d[win]  = 1'b0;
                    flight_d     = win;
                    flight_tag_d = tag_q[win];
                    last_d       = win;
                    state_d      = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (rom_ack == rom_req_q) begin
                    load_data_d      = rom_data;
                    load_tag_d       = flight_tag_q;
                    load_d[flight_q] = 1'b1;
                    state_d          = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (overrun_clr) begin
            overrun_d = '0;
        end

        // New requests land after the issue decision: a request for the channel being
        // issued refills its slot without counting as an overwrite.
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (ch_req[i]) begin
                if (pend_q[i] && !(issue && (win == CH_W'(i)))) begin
                    overrun_d[i] = 1'b1;
                end
                pend_d[i] = 1'b1;
                addr_d[i] = ch_addr[i*ADDR_W +: ADDR_W];
                tag_d[i]  = ch_tag[i*TAG_W +: TAG_W];
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= ST_IDLE;
            pend_q       <= '0;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                addr_q[i] <= '0;
                tag_q[i]  <= '0;
            end
            overrun_q    <= '0;
            load_q       <= '0;
            load_data_q  <= '0;
            load_tag_q   <= '0;
            flight_q     <= '0;
            flight_tag_q <= '0;
            last_q       <= CH_W'(NUM_CH - 1);
            rom_addr_q   <= '0;
            rom_req_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            pend_q       <= pend_d;
            addr_q       <= addr_d;
            tag_q        <= tag_d;
            overrun_q    <= overrun_d;
            load_q       <= load_d;
            load_data_q  <= load_data_d;
            load_tag_q   <= load_tag_d;
            flight_q     <= flight_d;
            flight_tag_q <= flight_tag_d;
            last_q       <= last_d;
            rom_addr_q   <= rom_addr_d;
            rom_req_q    <= rom_req_d;
        end
    end

    always_comb begin
        ch_busy = pend_q;
        if (state_q == ST_WAIT) begin
            ch_busy[flight_q] = 1'b1;
        end
    end

    assign load        = load_q;
    assign load_data   = load_data_q;
    assign load_tag    = load_tag_q;
    assign overrun     = overrun_q;
    assign rom_address = rom_addr_q;
    assign rom_req     = rom_req_q;

endmodule

// File: tb/tb_tile_rom_arbiter.sv
// Bench for tile_rom_arbiter: directed scenarios on round-robin and fixed-priority instances,
// plus randomized traffic checked against a transaction-level reference model.
module tb_tile_rom_arbiter;

    localparam int NCH = 4;
    localparam int AW  = 21;
    localparam int DW  = 32;
    localparam int TW  = 2;
    localparam int LAT = 3;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    // round-robin instance signals
    logic [NCH-1:0]    r_ch_req = '0;
    logic [NCH*AW-1:0] r_ch_addr = '0;
    logic [NCH*TW-1:0] r_ch_tag = '0;
    logic [NCH-1:0]    r_busy, r_load, r_ovr;
    logic [DW-1:0]     r_ldata;
    logic [TW-1:0]     r_ltag;
    logic              r_ovr_clr = 1'b0;
    logic [AW-1:0]     r_rom_addr;
    logic              r_rom_req;
    logic              r_rom_ack = 1'b0;
    logic [DW-1:0]     r_rom_data = '0;

    // fixed-priority instance signals
    logic [NCH-1:0]    p_ch_req = '0;
    logic [NCH*AW-1:0] p_ch_addr = '0;
    logic [NCH*TW-1:0] p_ch_tag = '0;
    logic [NCH-1:0]    p_busy, p_load, p_ovr;
    logic [DW-1:0]     p_ldata;
    logic [TW-1:0]     p_ltag;
    logic [AW-1:0]     p_rom_addr;
    logic              p_rom_req;
    logic              p_rom_ack = 1'b0;
    logic [DW-1:0]     p_rom_data = '0;

    int n_checks = 0;
    int n_fail   = 0;

    tile_rom_arbiter #(.NUM_CH(NCH), .ADDR_W(AW), .DATA_W(DW), .TAG_W(TW), .PRIO_MODE(0)) dut (
        .clk(clk), .resetn(resetn), .ch_req(r_ch_req), .ch_addr(r_ch_addr), .ch_tag(r_ch_tag),
        .ch_busy(r_busy), .load(r_load), .load_data(r_ldata), .load_tag(r_ltag),
        .overrun(r_ovr), .overrun_clr(r_ovr_clr), .rom_address(r_rom_addr),
        .rom_req(r_rom_req), .rom_ack(r_rom_ack), .rom_data(r_rom_data)
    );

    tile_rom_arbiter #(.NUM_CH(NCH), .ADDR_W(AW), .DATA_W(DW), .TAG_W(TW), .PRIO_MODE(1)) dut_p (
        .clk(clk), .resetn(resetn), .ch_req(p_ch_req), .ch_addr(p_ch_addr), .ch_tag(p_ch_tag),
        .ch_busy(p_busy), .load(p_load), .load_data(p_ldata), .load_tag(p_ltag),
        .overrun(p_ovr), .overrun_clr(1'b0), .rom_address(p_rom_addr),
        .rom_req(p_rom_req), .rom_ack(p_rom_ack), .rom_data(p_rom_data)
    );

    function automatic logic [DW-1:0] romf(input logic [AW-1:0] a);
        return (32'(a) * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    // ROM models: notice a toggle, answer LAT cycles later; hold_ack freezes the RR ROM.
    bit hold_ack = 0;
    logic r_seen = 1'b0, p_seen = 1'b0;
    int   r_cnt = 0, p_cnt = 0;

    always @(posedge clk) begin
        if (r_rom_req !== r_seen) begin
            r_seen <= r_rom_req;
            r_cnt  <= LAT;
        end else if (r_cnt > 0 && !hold_ack) begin
            r_cnt <= r_cnt - 1;
            if (r_cnt == 1) begin
                r_rom_ack  <= r_seen;
                r_rom_data <= romf(r_rom_addr);
            end
        end
    end

    always @(posedge clk) begin
        if (p_rom_req !== p_seen) begin
            p_seen <= p_rom_req;
            p_cnt  <= LAT;
        end else if (p_cnt > 0) begin
            p_cnt <= p_cnt - 1;
            if (p_cnt == 1) begin
                p_rom_ack  <= p_seen;
                p_rom_data <= romf(p_rom_addr);
            end
        end
    end

    // Monitors: record every issued address and every load strobe.
    typedef struct {
        logic [NCH-1:0] ld;
        logic [DW-1:0]  data;
        logic [TW-1:0]  tag;
    } ld_t;

    logic [AW-1:0] iss_q[$];
    ld_t           ld_q[$];
    ld_t           p_ld_q[$];
    logic          mon_prev_req = 1'b0;

    always @(negedge clk) begin
        if (r_rom_req !== mon_prev_req) iss_q.push_back(r_rom_addr);
        mon_prev_req = r_rom_req;
        if (r_load != '0) ld_q.push_back('{r_load, r_ldata, r_ltag});
        if (p_load != '0) p_ld_q.push_back('{p_load, p_ldata, p_ltag});
    end

    // Transaction-level reference for the round-robin instance.
    bit            m_pend [NCH];
    logic [AW-1:0] m_saddr[NCH];
    logic [TW-1:0] m_stag [NCH];
    bit            m_flight;
    int            m_fch, m_last;
    logic [TW-1:0] m_ftag;
    logic          m_req;
    logic [AW-1:0] m_addr;
    logic [NCH-1:0] m_load, m_ovr, m_set;
    logic [DW-1:0] m_ldata;
    logic [TW-1:0] m_ltag;
    int            m_w;

    function automatic int rr_pick();
        for (int d = 1; d <= NCH; d++)
            if (m_pend[(m_last + d) % NCH]) return (m_last + d) % NCH;
        return -1;
    endfunction

    function automatic logic [NCH-1:0] m_busy();
        logic [NCH-1:0] b;
        for (int i = 0; i < NCH; i++) b[i] = m_pend[i] || (m_flight && m_fch == i);
        return b;
    endfunction

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < NCH; i++) begin
                m_pend[i] = 0; m_saddr[i] = '0; m_stag[i] = '0;
            end
            m_flight = 0; m_fch = 0; m_ftag = '0; m_last = NCH - 1; m_req = 1'b0;
            m_addr = '0; m_load = '0; m_ldata = '0; m_ltag = '0; m_ovr = '0;
        end else begin
            m_load = '0;
            if (m_flight) begin
                if (r_rom_ack == m_req) begin
                    m_load = NCH'(1) << m_fch;
                    m_ldata = romf(m_addr);
                    m_ltag = m_ftag;
                    m_flight = 0;
                end
            end else if (r_rom_ack == m_req) begin
                m_w = rr_pick();
                if (m_w >= 0) begin
                    m_addr = m_saddr[m_w]; m_req = ~m_req; m_pend[m_w] = 0;
                    m_fch = m_w; m_ftag = m_stag[m_w]; m_last = m_w; m_flight = 1;
                end
            end
            m_set = '0;
            for (int i = 0; i < NCH; i++) begin
                if (r_ch_req[i]) begin
                    if (m_pend[i]) m_set[i] = 1'b1;
                    m_pend[i] = 1;
                    m_saddr[i] = r_ch_addr[i*AW +: AW];
                    m_stag[i] = r_ch_tag[i*TW +: TW];
                end
            end
            m_ovr = (r_ovr_clr ? '0 : m_ovr) | m_set;
        end
    end

    task automatic r_set(input int ch, input logic [AW-1:0] a, input logic [TW-1:0] t);
        r_ch_req[ch] = 1'b1;
        r_ch_addr[ch*AW +: AW] = a;
        r_ch_tag[ch*TW +: TW] = t;
    endtask

    task automatic p_set(input int ch, input logic [AW-1:0] a, input logic [TW-1:0] t);
        p_ch_req[ch] = 1'b1;
        p_ch_addr[ch*AW +: AW] = a;
        p_ch_tag[ch*TW +: TW] = t;
    endtask

    task automatic do_reset();
        @(negedge clk);
        r_ch_req = '0; p_ch_req = '0; r_ovr_clr = 1'b0; hold_ack = 0;
        resetn = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        repeat (8) @(negedge clk);
        iss_q.delete(); ld_q.delete(); p_ld_q.delete();
    endtask

    task automatic wait_loads(input int n, output bit ok);
        ok = 0;
        for (int c = 0; c < 400; c++) begin
            if (ld_q.size() >= n) begin ok = 1; break; end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        resetn = 1'b0;
        #1;
        n_checks++; if (r_rom_req !== 1'b0) begin n_fail++; $display("FAIL reset_rom_req got=%b want=0", r_rom_req); end
        n_checks++; if (r_rom_addr !== '0) begin n_fail++; $display("FAIL reset_rom_addr got=%h want=0", r_rom_addr); end
        n_checks++; if (r_load !== '0) begin n_fail++; $display("FAIL reset_load got=%b want=0", r_load); end
        n_checks++; if (r_ldata !== '0 || r_ltag !== '0) begin n_fail++; $display("FAIL reset_load_data got=%h/%h want=0/0", r_ldata, r_ltag); end
        n_checks++; if (r_ovr !== '0 || r_busy !== '0) begin n_fail++; $display("FAIL reset_ovr_busy got=%b/%b want=0/0", r_ovr, r_busy); end
        do_reset();
    endtask

    task automatic test_two_ch();
        bit ok;
        logic [AW-1:0] ea[2];
        logic [NCH-1:0] el[2];
        logic [TW-1:0] et[2];
        ea = '{21'h00100, 21'h00200}; el = '{4'b0001, 4'b0010}; et = '{2'd1, 2'd2};
        do_reset();
        r_set(0, 21'h00100, 2'd1);
        r_set(1, 21'h00200, 2'd2);
        @(negedge clk);
        r_ch_req = '0;
        n_checks++; if (r_busy !== 4'b0011) begin n_fail++; $display("FAIL two_busy got=%b want=0011", r_busy); end
        wait_loads(2, ok);
        n_checks++; if (!ok || iss_q.size() < 2) begin n_fail++; $display("FAIL two_timeout loads=%0d want=2", ld_q.size()); end
        else begin
            for (int k = 0; k < 2; k++) begin
                n_checks++; if (iss_q[k] !== ea[k]) begin n_fail++; $display("FAIL two_addr%0d got=%h want=%h", k, iss_q[k], ea[k]); end
                n_checks++; if (ld_q[k].ld !== el[k] || ld_q[k].tag !== et[k] || ld_q[k].data !== romf(ea[k])) begin
                    n_fail++; $display("FAIL two_load%0d got=%b/%h/%h want=%b/%h/%h", k, ld_q[k].ld, ld_q[k].tag, ld_q[k].data, el[k], et[k], romf(ea[k]));
                end
            end
        end
    endtask

    task automatic test_round_robin();
        int c;
        do_reset();
        c = 0;
        while (ld_q.size() < 8 && c < 600) begin
            for (int ch = 0; ch < NCH; ch++) r_set(ch, AW'((ch << 12) | c), TW'(ch));
            @(negedge clk);
            c++;
        end
        r_ch_req = '0;
        n_checks++; if (ld_q.size() < 8) begin n_fail++; $display("FAIL rr_timeout loads=%0d want=8", ld_q.size()); end
        else begin
            for (int k = 0; k < 8; k++) begin
                n_checks++; if (ld_q[k].ld !== (NCH'(1) << (k % NCH)) || ld_q[k].tag !== TW'(k % NCH)) begin
                    n_fail++; $display("FAIL rr_order%0d got=%b/%0d want=%b/%0d", k, ld_q[k].ld, ld_q[k].tag, NCH'(1) << (k % NCH), k % NCH);
                end
            end
        end
    endtask

    task automatic test_prio();
        int n1;
        bit done;
        do_reset();
        p_set(1, 21'h00111, 2'd1);
        p_set(3, 21'h00333, 2'd3);
        done = 0;
        for (int c = 0; c < 600 && !done; c++) begin
            @(negedge clk);
            p_ch_req = '0;
            n1 = 0;
            foreach (p_ld_q[k]) begin
                if (p_ld_q[k].ld == 4'b0010) n1++;
                if (p_ld_q[k].ld == 4'b1000) done = 1;
            end
            if (n1 < 4) p_set(1, AW'(21'h00100 + c), 2'd1);
        end
        p_ch_req = '0;
        n_checks++; if (!done) begin n_fail++; $display("FAIL prio_timeout ch3 never served loads=%0d", p_ld_q.size()); end
        else begin
            n_checks++; if (p_ld_q.size() < 5) begin n_fail++; $display("FAIL prio_count got=%0d want>=5", p_ld_q.size()); end
            for (int k = 0; k < p_ld_q.size() - 1; k++) begin
                n_checks++; if (p_ld_q[k].ld !== 4'b0010) begin n_fail++; $display("FAIL prio_ch1_%0d got=%b want=0010", k, p_ld_q[k].ld); end
            end
            n_checks++;
            if (p_ld_q[$].ld !== 4'b1000 || p_ld_q[$].tag !== 2'd3 || p_ld_q[$].data !== romf(21'h00333)) begin
                n_fail++; $display("FAIL prio_ch3 got=%b/%0d/%h want=1000/3/%h", p_ld_q[$].ld, p_ld_q[$].tag, p_ld_q[$].data, romf(21'h00333));
            end
        end
    endtask

    task automatic test_overrun();
        bit ok;
        do_reset();
        r_set(1, 21'h00040, 2'd3);
        @(negedge clk); r_ch_req = '0;
        @(negedge clk); r_set(0, 21'h00010, 2'd0);
        @(negedge clk); r_ch_req = '0; r_set(0, 21'h00020, 2'd1);
        @(negedge clk); r_ch_req = '0;
        n_checks++; if (r_ovr !== 4'b0001) begin n_fail++; $display("FAIL ovr_set got=%b want=0001", r_ovr); end
        n_checks++; if (r_busy !== 4'b0011) begin n_fail++; $display("FAIL ovr_busy got=%b want=0011", r_busy); end
        wait_loads(2, ok);
        n_checks++; if (!ok || iss_q.size() < 2) begin n_fail++; $display("FAIL ovr_timeout loads=%0d want=2", ld_q.size()); end
        else begin
            n_checks++; if (iss_q[0] !== 21'h00040 || iss_q[1] !== 21'h00020) begin
                n_fail++; $display("FAIL ovr_addrs got=%h,%h want=00040,00020", iss_q[0], iss_q[1]);
            end
            n_checks++; if (ld_q[1].ld !== 4'b0001 || ld_q[1].tag !== 2'd1 || ld_q[1].data !== romf(21'h00020)) begin
                n_fail++; $display("FAIL ovr_load got=%b/%0d/%h want=0001/1/%h", ld_q[1].ld, ld_q[1].tag, ld_q[1].data, romf(21'h00020));
            end
        end
        repeat (10) @(negedge clk);
        n_checks++; if (iss_q.size() != 2) begin n_fail++; $display("FAIL ovr_extra_issue got=%0d want=2", iss_q.size()); end
        n_checks++; if (r_ovr !== 4'b0001) begin n_fail++; $display("FAIL ovr_sticky got=%b want=0001", r_ovr); end
        r_ovr_clr = 1'b1;
        @(negedge clk); r_ovr_clr = 1'b0;
        n_checks++; if (r_ovr !== 4'b0000) begin n_fail++; $display("FAIL ovr_clear got=%b want=0000", r_ovr); end
    endtask

    task automatic test_grant_cycle();
        bit ok;
        do_reset();
        r_set(0, 21'h00010, 2'd2);
        @(negedge clk); r_ch_req = '0; r_set(0, 21'h00030, 2'd3);
        @(negedge clk); r_ch_req = '0;
        n_checks++; if (r_rom_addr !== 21'h00010 || r_busy !== 4'b0001) begin
            n_fail++; $display("FAIL grant_issue got=%h/%b want=00010/0001", r_rom_addr, r_busy);
        end
        wait_loads(2, ok);
        n_checks++; if (!ok || iss_q.size() < 2) begin n_fail++; $display("FAIL grant_timeout loads=%0d want=2", ld_q.size()); end
        else begin
            n_checks++; if (iss_q[0] !== 21'h00010 || iss_q[1] !== 21'h00030) begin
                n_fail++; $display("FAIL grant_addrs got=%h,%h want=00010,00030", iss_q[0], iss_q[1]);
            end
            n_checks++; if (ld_q[0].tag !== 2'd2 || ld_q[1].tag !== 2'd3 || ld_q[1].data !== romf(21'h00030)) begin
                n_fail++; $display("FAIL grant_loads got=%0d,%0d/%h want=2,3/%h", ld_q[0].tag, ld_q[1].tag, ld_q[1].data, romf(21'h00030));
            end
        end
        n_checks++; if (r_ovr !== '0) begin n_fail++; $display("FAIL grant_ovr got=%b want=0000", r_ovr); end
    endtask

    task automatic test_reset_in_wait();
        bit ok;
        int c;
        do_reset();
        r_set(0, 21'h00010, 2'd0);
        @(negedge clk); r_ch_req = '0;
        wait_loads(1, ok);
        r_set(0, 21'h00020, 2'd1);
        @(negedge clk); r_ch_req = '0;
        c = 0;
        while (r_rom_req !== 1'b0 && c < 50) begin @(negedge clk); c++; end
        hold_ack = 1;
        n_checks++; if (r_rom_req !== 1'b0 || r_rom_ack !== 1'b1) begin
            n_fail++; $display("FAIL rw_setup req/ack got=%b/%b want=0/1", r_rom_req, r_rom_ack);
        end
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        ld_q.delete(); iss_q.delete();
        n_checks++; if (r_rom_req !== 1'b0 || r_load !== '0 || r_busy !== '0) begin
            n_fail++; $display("FAIL rw_reset got=%b/%b/%b want=0/0000/0000", r_rom_req, r_load, r_busy);
        end
        r_set(0, 21'h00050, 2'd2);
        @(negedge clk); r_ch_req = '0;
        repeat (10) @(negedge clk);
        n_checks++; if (r_rom_req !== 1'b0 || ld_q.size() != 0 || r_busy !== 4'b0001) begin
            n_fail++; $display("FAIL rw_stale_hold got=%b/%0d/%b want=0/0/0001", r_rom_req, ld_q.size(), r_busy);
        end
        hold_ack = 0;
        wait_loads(1, ok);
        n_checks++; if (!ok || iss_q.size() < 1) begin n_fail++; $display("FAIL rw_timeout loads=%0d want=1", ld_q.size()); end
        else begin
            n_checks++; if (iss_q[0] !== 21'h00050 || ld_q[0].ld !== 4'b0001 || ld_q[0].data !== romf(21'h00050) || ld_q[0].tag !== 2'd2) begin
                n_fail++; $display("FAIL rw_fresh got=%h/%b/%h/%0d want=00050/0001/%h/2", iss_q[0], ld_q[0].ld, ld_q[0].data, ld_q[0].tag, romf(21'h00050));
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 800; c++) begin
            n_checks++; if (r_rom_req !== m_req) begin n_fail++; $display("FAIL rnd_rom_req c=%0d got=%b want=%b", c, r_rom_req, m_req); end
            n_checks++; if (r_rom_addr !== m_addr) begin n_fail++; $display("FAIL rnd_rom_addr c=%0d got=%h want=%h", c, r_rom_addr, m_addr); end
            n_checks++; if (r_load !== m_load) begin n_fail++; $display("FAIL rnd_load c=%0d got=%b want=%b", c, r_load, m_load); end
            n_checks++; if (r_ldata !== m_ldata || r_ltag !== m_ltag) begin
                n_fail++; $display("FAIL rnd_load_data c=%0d got=%h/%0d want=%h/%0d", c, r_ldata, r_ltag, m_ldata, m_ltag);
            end
            n_checks++; if (r_ovr !== m_ovr) begin n_fail++; $display("FAIL rnd_overrun c=%0d got=%b want=%b", c, r_ovr, m_ovr); end
            n_checks++; if (r_busy !== m_busy()) begin n_fail++; $display("FAIL rnd_busy c=%0d got=%b want=%b", c, r_busy, m_busy()); end
            r_ch_req = NCH'($urandom_range(0, 15) & $urandom_range(0, 15));
            r_ch_addr = {$urandom(), $urandom(), $urandom()};
            r_ch_tag = NCH*TW'($urandom());
            r_ovr_clr = ($urandom_range(0, 15) == 0);
            @(negedge clk);
        end
        r_ch_req = '0;
        r_ovr_clr = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish");
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail + 1);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_two_ch();
        test_round_robin();
        test_prio();
        test_overrun();
        test_grant_cycle();
        test_reset_in_wait();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
